// File: rtl/clk_lock_monitor_pkg.sv
// Shared types and constants for the divided-clock lock monitor.
package clk_lock_monitor_pkg;

  typedef enum logic [1:0] {
    StSearch  = 2'd0,
    StAcquire = 2'd1,
    StLocked  = 2'd2
  } lock_state_e;

  localparam int unsigned HalfPeriod2f = 2;
  localparam int unsigned HalfPeriodF  = 4;
  localparam int unsigned RunCntW      = 4;

endpackage

// File: rtl/clk_lock_monitor_run_counter.sv
// Samples one divided clock, detects its edges and checks each half-period length
// against HalfPeriod; also flags a single timeout when a half-period overruns.
module clk_run_counter
  import clk_lock_monitor_pkg::*;
#(
  parameter int unsigned HalfPeriod = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clk_div_i,
  output logic edge_o,
  output logic err_o
);

  localparam logic [RunCntW-1:0] CntExp  = RunCntW'(HalfPeriod);
  localparam logic [RunCntW-1:0] CntLate = RunCntW'(HalfPeriod + 1);
  localparam logic [RunCntW-1:0] CntMax  = '1;

  logic               samp_q, prev_q;
  logic [RunCntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      samp_q <= 1'b0;
      prev_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      samp_q <= clk_div_i;
      prev_q <= samp_q;
      cnt_q  <= cnt_d;
    end
  end

  assign edge_o = samp_q ^ prev_q;

  always_comb begin
    cnt_d = cnt_q;
    if (edge_o) begin
      cnt_d = RunCntW'(1);
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + RunCntW'(1);
    end
  end

  // Timeout matches a single count value, so a stall is reported exactly once.
  assign err_o = edge_o ? (cnt_q != CntExp) : (cnt_q == CntLate);

endmodule

// File: rtl/clk_lock_monitor.sv
// Lock monitor for the 2f/f divided clocks, clocked only by clk_8f.
// Define CLK_LOCK_MONITOR_PHASE_EN to add the f-vs-2f edge coincidence check.
module clk_lock_monitor
  import clk_lock_monitor_pkg::*;
#(
  parameter int unsigned LOCK_CYCLES = 4
) (
  input  logic       clk_8f,
  input  logic       reset,
  input  logic       clk_2f_in,
  input  logic       clk_f_in,
  output logic       locked,
  output logic       err_2f,
  output logic       err_f,
  output logic       err_phase,
  output logic [1:0] state
);

  localparam logic [RunCntW:0]   LockTarget = (RunCntW + 1)'(LOCK_CYCLES);
  localparam logic [RunCntW-1:0] GoodMax    = '1;

  lock_state_e        state_q, state_d;
  logic [RunCntW-1:0] good_q, good_d;
  logic [RunCntW:0]   good_inc;
  logic               err_2f_q, err_2f_d, err_f_q, err_f_d;
  logic               f2_edge, f2_err, f_edge, f_err;
  logic               checking, phase_err;

  clk_run_counter #(
    .HalfPeriod(HalfPeriod2f)
  ) u_run_2f (
    .clk_i    (clk_8f),
    .rst_ni   (reset),
    .clk_div_i(clk_2f_in),
    .edge_o   (f2_edge),
    .err_o    (f2_err)
  );

  clk_run_counter #(
    .HalfPeriod(HalfPeriodF)
  ) u_run_f (
    .clk_i    (clk_8f),
    .rst_ni   (reset),
    .clk_div_i(clk_f_in),
    .edge_o   (f_edge),
    .err_o    (f_err)
  );

  assign checking = (state_q != StSearch);

`ifdef CLK_LOCK_MONITOR_PHASE_EN
  logic err_phase_q;

  assign phase_err = checking & f_edge & ~f2_edge;

  always_ff @(posedge clk_8f or negedge reset) begin
    if (!reset) begin
      err_phase_q <= 1'b0;
    end else begin
      err_phase_q <= phase_err;
    end
  end

  assign err_phase = err_phase_q;
`else
  logic unused_f2_edge;

  assign unused_f2_edge = f2_edge;
  assign phase_err      = 1'b0;
  assign err_phase      = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    good_d   = good_q;
    err_2f_d = checking & f2_err;
    err_f_d  = checking & f_err;
    good_inc = {1'b0, good_q} + 1'b1;

    // Any error wins over the edge that caused it, so that edge never re-enters ACQUIRE.
    if (err_2f_d || err_f_d || phase_err) begin
      state_d = StSearch;
      good_d  = '0;
    end else begin
      unique case (state_q)
        StSearch: begin
          if (f_edge) begin
            state_d = StAcquire;
            good_d  = '0;
          end
        end
        StAcquire: begin
          if (f_edge) begin
            if (good_q != GoodMax) begin
              good_d = good_inc[RunCntW-1:0];
            end
            if (good_inc >= LockTarget) begin
              state_d = StLocked;
            end
          end
        end
        StLocked: ;
        default: begin
          state_d = StSearch;
          good_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_8f or negedge reset) begin
    if (!reset) begin
      state_q  <= StSearch;
      good_q   <= '0;
      err_2f_q <= 1'b0;
      err_f_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      good_q   <= good_d;
      err_2f_q <= err_2f_d;
      err_f_q  <= err_f_d;
    end
  end

  assign locked = (state_q == StLocked);
  assign err_2f = err_2f_q;
  assign err_f  = err_f_q;
  assign state  = state_q;

endmodule
